axi2mem_tcdm_wr_unit: RTL and testbench

//  Write-side TCDM back end of the axi2mem bridge. Consumes the per-port write

---
 rtl/axi2mem_tcdm_wr_unit.sv | 187 ++++++++++++++++++
 tb/tb_axi2mem_tcdm_wr_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi2mem_tcdm_wr_unit.sv
// Write-side TCDM back end of the axi2mem bridge. Each 64-bit AXI beat is split into two
// 32-bit TCDM writes (port 0 = low word, port 1 = high word). One completion id is
// returned per burst once both ports have retired their last word.
module axi2mem_tcdm_wr_unit #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID_WIDTH   = 6,
   parameter int unsigned CMD_DEPTH  = 4,
   parameter int unsigned DATA_DEPTH = 4,
   parameter int unsigned RESP_DEPTH = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             test_en_i,
   input  logic [1:0][ID_WIDTH-1:0]         trans_id_i,
   input  logic [1:0][ADDR_WIDTH-1:0]       trans_add_i,
   input  logic [1:0]                       trans_last_i,
   input  logic [1:0]                       trans_req_i,
   output logic [1:0]                       trans_gnt_o,
   input  logic [63:0]                      data_dat_i,
   input  logic [7:0]                       data_strb_i,
   input  logic                             data_req_i,
   output logic                             data_gnt_o,
   output logic [1:0]                       tcdm_req_o,
   output logic [1:0][ADDR_WIDTH-1:0]       tcdm_add_o,
   output logic [1:0]                       tcdm_wen_o,
   output logic [1:0][31:0]                 tcdm_wdata_o,
   output logic [1:0][3:0]                  tcdm_be_o,
   input  logic [1:0]                       tcdm_gnt_i,
   output logic                             trans_r_req_o,
   output logic [ID_WIDTH-1:0]              trans_r_id_o,
   input  logic                             trans_r_gnt_i
);

   localparam int unsigned CmdPtrW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int unsigned CmdCntW = $clog2(CMD_DEPTH) + 1;
   localparam int unsigned DatPtrW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
   localparam int unsigned DatCntW = $clog2(DATA_DEPTH) + 1;
   localparam int unsigned RspPtrW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int unsigned RspCntW = $clog2(RESP_DEPTH) + 1;
   localparam int unsigned LcW     = $clog2(RESP_DEPTH) + 1;

   logic                            unused_test_en;
   logic [1:0]                      head_valid, head_last, pop, stall;
   logic [1:0][ID_WIDTH-1:0]        head_id;
   logic [1:0][ADDR_WIDTH-1:0]      head_add;
   logic [1:0][31:0]                head_dat;
   logic [1:0][3:0]                 head_be;
   logic [1:0]                      cmd_full, dat_full;
   logic                            dat_push;

   logic [ID_WIDTH-1:0]             r_mem [RESP_DEPTH];
   logic [RspPtrW-1:0]              r_wptr_q, r_rptr_q;
   logic [RspCntW-1:0]              r_cnt_q;
   logic                            resp_push, resp_pop, resp_full;
   logic [1:0][LcW-1:0]             last_cnt_q;

   assign unused_test_en = test_en_i;

   // Both data halves are pushed together, so either full data FIFO stalls the beat.
   assign data_gnt_o = ~dat_full[0] & ~dat_full[1];
   assign dat_push   = data_req_i & data_gnt_o;
   assign tcdm_wen_o = '0;

   for (genvar i = 0; i < 2; i++) begin : g_port
      logic [ID_WIDTH-1:0]   cid_mem  [CMD_DEPTH];
      logic [ADDR_WIDTH-1:0] cadd_mem [CMD_DEPTH];
      logic                  clast_mem[CMD_DEPTH];
      logic [31:0]           dat_mem  [DATA_DEPTH];
      logic [3:0]            be_mem   [DATA_DEPTH];
      logic [CmdPtrW-1:0]    c_wptr_q, c_rptr_q;
      logic [CmdCntW-1:0]    c_cnt_q;
      logic [DatPtrW-1:0]    d_wptr_q, d_rptr_q;
      logic [DatCntW-1:0]    d_cnt_q;
      logic                  cmd_push;

      assign cmd_full[i]    = (c_cnt_q == CmdCntW'(CMD_DEPTH));
      assign dat_full[i]    = (d_cnt_q == DatCntW'(DATA_DEPTH));
      assign trans_gnt_o[i] = ~cmd_full[i];
      assign cmd_push       = trans_req_i[i] & trans_gnt_o[i];

      assign head_valid[i] = (c_cnt_q != '0) & (d_cnt_q != '0);
      assign head_id[i]    = head_valid[i] ? cid_mem[c_rptr_q]   : '0;
      assign head_add[i]   = head_valid[i] ? cadd_mem[c_rptr_q]  : '0;
      assign head_last[i]  = head_valid[i] ? clast_mem[c_rptr_q] : 1'b0;
      assign head_dat[i]   = head_valid[i] ? dat_mem[d_rptr_q]   : '0;
      assign head_be[i]    = head_valid[i] ? be_mem[d_rptr_q]    : '0;

      // A word with no strobes is retired without touching the TCDM.
      assign pop[i]          = head_valid[i] & ~stall[i] & ((head_be[i] == 4'h0) | tcdm_gnt_i[i]);
      assign tcdm_req_o[i]   = head_valid[i] & ~stall[i] & (head_be[i] != 4'h0);
      assign tcdm_add_o[i]   = head_add[i];
      assign tcdm_wdata_o[i] = head_dat[i];
      assign tcdm_be_o[i]    = head_be[i];

      // FIFO storage writes
      always_ff @(posedge clk_i) begin
         if (cmd_push) begin
            cid_mem[c_wptr_q]   <= trans_id_i[i];
            cadd_mem[c_wptr_q]  <= trans_add_i[i];
            clast_mem[c_wptr_q] <= trans_last_i[i];
         end
         if (dat_push) begin
            dat_mem[d_wptr_q] <= data_dat_i[32*i +: 32];
            be_mem[d_wptr_q]  <= data_strb_i[4*i +: 4];
         end
      end

      // FIFO pointers and occupancy
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            c_wptr_q <= '0;
            c_rptr_q <= '0;
            c_cnt_q  <= '0;
            d_wptr_q <= '0;
            d_rptr_q <= '0;
            d_cnt_q  <= '0;
         end else begin
            if (cmd_push) begin
               c_wptr_q <= (c_wptr_q == CmdPtrW'(CMD_DEPTH - 1)) ? '0 : c_wptr_q + CmdPtrW'(1);
            end
            if (dat_push) begin
               d_wptr_q <= (d_wptr_q == DatPtrW'(DATA_DEPTH - 1)) ? '0 : d_wptr_q + DatPtrW'(1);
            end
            if (pop[i]) begin
               c_rptr_q <= (c_rptr_q == CmdPtrW'(CMD_DEPTH - 1)) ? '0 : c_rptr_q + CmdPtrW'(1);
               d_rptr_q <= (d_rptr_q == DatPtrW'(DATA_DEPTH - 1)) ? '0 : d_rptr_q + DatPtrW'(1);
            end
            case ({cmd_push, pop[i]})
               2'b10:   c_cnt_q <= c_cnt_q + CmdCntW'(1);
               2'b01:   c_cnt_q <= c_cnt_q - CmdCntW'(1);
               default: c_cnt_q <= c_cnt_q;
            endcase
            case ({dat_push, pop[i]})
               2'b10:   d_cnt_q <= d_cnt_q + DatCntW'(1);
               2'b01:   d_cnt_q <= d_cnt_q - DatCntW'(1);
               default: d_cnt_q <= d_cnt_q;
            endcase
         end
      end
   end

   // Port 0 owns the completion id; it may not retire a last word while the id cannot be stored.
   assign stall     = {1'b0, head_last[0] & resp_full};
   assign resp_full = (r_cnt_q == RspCntW'(RESP_DEPTH));
   assign resp_push = pop[0] & head_last[0];

   assign trans_r_req_o = (r_cnt_q != '0) & (last_cnt_q[0] != '0) & (last_cnt_q[1] != '0);
   assign trans_r_id_o  = (r_cnt_q != '0) ? r_mem[r_rptr_q] : '0;
   assign resp_pop      = trans_r_req_o & trans_r_gnt_i;

   // Completion id storage write
   always_ff @(posedge clk_i) begin
      if (resp_push) begin
         r_mem[r_wptr_q] <= head_id[0];
      end
   end

   // Completion FIFO pointers and per-port finished-burst counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr_q   <= '0;
         r_rptr_q   <= '0;
         r_cnt_q    <= '0;
         last_cnt_q <= '0;
      end else begin
         if (resp_push) begin
            r_wptr_q <= (r_wptr_q == RspPtrW'(RESP_DEPTH - 1)) ? '0 : r_wptr_q + RspPtrW'(1);
         end
         if (resp_pop) begin
            r_rptr_q <= (r_rptr_q == RspPtrW'(RESP_DEPTH - 1)) ? '0 : r_rptr_q + RspPtrW'(1);
         end
         case ({resp_push, resp_pop})
            2'b10:   r_cnt_q <= r_cnt_q + RspCntW'(1);
            2'b01:   r_cnt_q <= r_cnt_q - RspCntW'(1);
            default: r_cnt_q <= r_cnt_q;
         endcase
         for (int i = 0; i < 2; i++) begin
            case ({pop[i] & head_last[i], resp_pop})
               2'b10:   last_cnt_q[i] <= last_cnt_q[i] + LcW'(1);
               2'b01:   last_cnt_q[i] <= last_cnt_q[i] - LcW'(1);
               default: last_cnt_q[i] <= last_cnt_q[i];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axi2mem_tcdm_wr_unit.sv
// Directed bench for axi2mem_tcdm_wr_unit: beat splitting, per-port stalls, narrow beats,
// FIFO back-pressure, completion ordering and asynchronous reset mid-burst.
module tb_axi2mem_tcdm_wr_unit;

   localparam int unsigned IdW = 6;
   localparam int unsigned AW  = 32;

   logic                   clk_i = 1'b0;
   logic                   rst_ni = 1'b0;
   logic                   test_en_i = 1'b0;
   logic [1:0][IdW-1:0]    trans_id_i = '0;
   logic [1:0][AW-1:0]     trans_add_i = '0;
   logic [1:0]             trans_last_i = '0;
   logic [1:0]             trans_req_i = '0;
   logic [1:0]             trans_gnt_o;
   logic [63:0]            data_dat_i = '0;
   logic [7:0]             data_strb_i = '0;
   logic                   data_req_i = 1'b0;
   logic                   data_gnt_o;
   logic [1:0]             tcdm_req_o;
   logic [1:0][AW-1:0]     tcdm_add_o;
   logic [1:0]             tcdm_wen_o;
   logic [1:0][31:0]       tcdm_wdata_o;
   logic [1:0][3:0]        tcdm_be_o;
   logic [1:0]             tcdm_gnt_i = 2'b11;
   logic                   trans_r_req_o;
   logic [IdW-1:0]         trans_r_id_o;
   logic                   trans_r_gnt_i = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   axi2mem_tcdm_wr_unit #(
      .ADDR_WIDTH (AW),
      .ID_WIDTH   (IdW),
      .CMD_DEPTH  (4),
      .DATA_DEPTH (4),
      .RESP_DEPTH (4)
   ) u_dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .test_en_i     (test_en_i),
      .trans_id_i    (trans_id_i),
      .trans_add_i   (trans_add_i),
      .trans_last_i  (trans_last_i),
      .trans_req_i   (trans_req_i),
      .trans_gnt_o   (trans_gnt_o),
      .data_dat_i    (data_dat_i),
      .data_strb_i   (data_strb_i),
      .data_req_i    (data_req_i),
      .data_gnt_o    (data_gnt_o),
      .tcdm_req_o    (tcdm_req_o),
      .tcdm_add_o    (tcdm_add_o),
      .tcdm_wen_o    (tcdm_wen_o),
      .tcdm_wdata_o  (tcdm_wdata_o),
      .tcdm_be_o     (tcdm_be_o),
      .tcdm_gnt_i    (tcdm_gnt_i),
      .trans_r_req_o (trans_r_req_o),
      .trans_r_id_o  (trans_r_id_o),
      .trans_r_gnt_i (trans_r_gnt_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_beat(input logic [IdW-1:0] id, input logic [31:0] a0, input logic [31:0] a1,
                           input logic last, input logic [63:0] d, input logic [7:0] s);
      trans_req_i    = 2'b11;
      trans_id_i[0]  = id;
      trans_id_i[1]  = id;
      trans_add_i[0] = a0;
      trans_add_i[1] = a1;
      trans_last_i   = {last, last};
      data_dat_i     = d;
      data_strb_i    = s;
      data_req_i     = 1'b1;
   endtask

   task automatic clr_in();
      trans_req_i = 2'b00;
      data_req_i  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] lo;
      logic [31:0] hi;
      logic [IdW-1:0] id;

      // Reset state
      repeat (2) cyc();
      check("rst_tcdm_req", tcdm_req_o, 2'b00);
      check("rst_r_req", trans_r_req_o, 1'b0);
      check("rst_trans_gnt", trans_gnt_o, 2'b11);
      check("rst_data_gnt", data_gnt_o, 1'b1);
      check("rst_add0", tcdm_add_o[0], 32'h0);
      check("rst_wdata1", tcdm_wdata_o[1], 32'h0);
      check("rst_wen", tcdm_wen_o, 2'b00);
      rst_ni = 1'b1;
      cyc();

      // Single beat, full strobes
      tcdm_gnt_i = 2'b11;
      trans_r_gnt_i = 1'b0;
      set_beat(6'h11, 32'h100, 32'h104, 1'b1, 64'hBBBB_BBBB_AAAA_AAAA, 8'hFF);
      cyc();
      clr_in();
      #1;
      check("t1_req", tcdm_req_o, 2'b11);
      check("t1_add0", tcdm_add_o[0], 32'h100);
      check("t1_add1", tcdm_add_o[1], 32'h104);
      check("t1_wd0", tcdm_wdata_o[0], 32'hAAAA_AAAA);
      check("t1_wd1", tcdm_wdata_o[1], 32'hBBBB_BBBB);
      check("t1_be0", tcdm_be_o[0], 4'hF);
      check("t1_be1", tcdm_be_o[1], 4'hF);
      check("t1_rreq_early", trans_r_req_o, 1'b0);
      cyc();
      check("t1_req_done", tcdm_req_o, 2'b00);
      check("t1_rreq", trans_r_req_o, 1'b1);
      check("t1_rid", trans_r_id_o, 6'h11);
      trans_r_gnt_i = 1'b1;
      cyc();
      check("t1_rreq_pop", trans_r_req_o, 1'b0);

      // 4-beat burst, port 1 stalled for three cycles
      tcdm_gnt_i = 2'b01;
      trans_r_gnt_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         lo = 32'h1000_0000 + 32'(k);
         hi = 32'h2000_0000 + 32'(k);
         set_beat(6'd5, 32'h300 + 32'(8 * k), 32'h304 + 32'(8 * k), (k == 3), {hi, lo}, 8'hFF);
         cyc();
         check("t2_add0", tcdm_add_o[0], 32'h300 + 32'(8 * k));
         check("t2_wd0", tcdm_wdata_o[0], lo);
         if (k < 3) begin
            check("t2_req1_hold", tcdm_req_o[1], 1'b1);
            check("t2_add1_hold", tcdm_add_o[1], 32'h304);
            check("t2_wd1_hold", tcdm_wdata_o[1], 32'h2000_0000);
         end
         if (k == 2) tcdm_gnt_i = 2'b11;
      end
      clr_in();
      check("t2_add1_adv", tcdm_add_o[1], 32'h30C);
      check("t2_rreq_a", trans_r_req_o, 1'b0);
      cyc();
      check("t2_rreq_b", trans_r_req_o, 1'b0);
      cyc();
      check("t2_add1_last", tcdm_add_o[1], 32'h31C);
      check("t2_wd1_last", tcdm_wdata_o[1], 32'h2000_0003);
      check("t2_rreq_c", trans_r_req_o, 1'b0);
      cyc();
      check("t2_rreq", trans_r_req_o, 1'b1);
      check("t2_rid", trans_r_id_o, 6'd5);
      check("t2_req_idle", tcdm_req_o, 2'b00);
      trans_r_gnt_i = 1'b1;
      cyc();
      check("t2_single_cpl", trans_r_req_o, 1'b0);

      // Narrow beat: high word has no strobes and is dropped
      tcdm_gnt_i = 2'b00;
      trans_r_gnt_i = 1'b0;
      set_beat(6'd7, 32'h200, 32'h200, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
      cyc();
      clr_in();
      check("t3_req", tcdm_req_o, 2'b01);
      check("t3_add0", tcdm_add_o[0], 32'h200);
      check("t3_wd0", tcdm_wdata_o[0], 32'hCAFE_F00D);
      check("t3_be0", tcdm_be_o[0], 4'hF);
      tcdm_gnt_i = 2'b01;
      cyc();
      check("t3_req_done", tcdm_req_o, 2'b00);
      check("t3_rreq", trans_r_req_o, 1'b1);
      check("t3_rid", trans_r_id_o, 6'd7);
      trans_r_gnt_i = 1'b1;
      cyc();
      check("t3_rreq_pop", trans_r_req_o, 1'b0);

      // Fill the FIFOs with no TCDM grant
      tcdm_gnt_i = 2'b00;
      for (int k = 0; k < 4; k++) begin
         id = 6'd8 + IdW'(k);
         set_beat(id, 32'h400 + 32'(8 * k), 32'h404 + 32'(8 * k), 1'b1,
                  {32'h4000_0000 + 32'(k), 32'h3000_0000 + 32'(k)}, 8'hFF);
         cyc();
      end
      check("t4_tgnt_full", trans_gnt_o, 2'b00);
      check("t4_dgnt_full", data_gnt_o, 1'b0);
      cyc();
      check("t4_tgnt_hold", trans_gnt_o, 2'b00);
      clr_in();
      check("t4_head_kept", tcdm_add_o[0], 32'h400);
      tcdm_gnt_i = 2'b11;
      #1;
      check("t4_tgnt_nocomb", trans_gnt_o, 2'b00);
      cyc();
      check("t4_tgnt_free", trans_gnt_o, 2'b11);
      check("t4_dgnt_free", data_gnt_o, 1'b1);
      check("t4_rreq0", trans_r_req_o, 1'b1);
      check("t4_rid0", trans_r_id_o, 6'd8);
      for (int k = 1; k < 4; k++) begin
         cyc();
         check("t4_rreq", trans_r_req_o, 1'b1);
         check("t4_rid", trans_r_id_o, 6'd8 + IdW'(k));
      end
      cyc();
      check("t4_rreq_empty", trans_r_req_o, 1'b0);

      // Completions held while not granted, then drained in order
      tcdm_gnt_i = 2'b11;
      trans_r_gnt_i = 1'b0;
      for (int k = 1; k < 4; k++) begin
         set_beat(IdW'(k), 32'h500 + 32'(8 * k), 32'h504 + 32'(8 * k), 1'b1, 64'h5555_0000_6666_0000,
                  8'hFF);
         cyc();
      end
      clr_in();
      check("t5_rreq_a", trans_r_req_o, 1'b1);
      check("t5_rid_a", trans_r_id_o, 6'd1);
      cyc();
      cyc();
      check("t5_rreq_held", trans_r_req_o, 1'b1);
      check("t5_rid_held", trans_r_id_o, 6'd1);
      trans_r_gnt_i = 1'b1;
      #1;
      check("t5_rid_gnt", trans_r_id_o, 6'd1);
      cyc();
      check("t5_rid2", trans_r_id_o, 6'd2);
      cyc();
      check("t5_rid3", trans_r_id_o, 6'd3);
      check("t5_rreq3", trans_r_req_o, 1'b1);
      cyc();
      check("t5_rreq_empty", trans_r_req_o, 1'b0);

      // Asynchronous reset mid-burst
      tcdm_gnt_i = 2'b00;
      for (int k = 0; k < 2; k++) begin
         set_beat(6'd9, 32'h600 + 32'(8 * k), 32'h604 + 32'(8 * k), 1'b0, 64'h7777_0000_8888_0000,
                  8'hFF);
         cyc();
      end
      clr_in();
      check("t6_req_pre", tcdm_req_o, 2'b11);
      #2;
      rst_ni = 1'b0;
      #1;
      check("t6_req_rst", tcdm_req_o, 2'b00);
      check("t6_rreq_rst", trans_r_req_o, 1'b0);
      check("t6_tgnt_rst", trans_gnt_o, 2'b11);
      check("t6_dgnt_rst", data_gnt_o, 1'b1);
      cyc();
      rst_ni = 1'b1;
      tcdm_gnt_i = 2'b11;
      cyc();
      check("t6_req_post", tcdm_req_o, 2'b00);
      check("t6_rreq_post", trans_r_req_o, 1'b0);
      set_beat(6'h2A, 32'h700, 32'h704, 1'b1, 64'h9999_9999_1111_1111, 8'hFF);
      cyc();
      clr_in();
      check("t6_new_req", tcdm_req_o, 2'b11);
      check("t6_new_add0", tcdm_add_o[0], 32'h700);
      check("t6_new_wd1", tcdm_wdata_o[1], 32'h9999_9999);
      cyc();
      check("t6_new_rreq", trans_r_req_o, 1'b1);
      check("t6_new_rid", trans_r_id_o, 6'h2A);
      cyc();
      check("t6_new_done", trans_r_req_o, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
